// File: rtl/mem_periph_bus_pkg.sv
// Shared definitions for the MEM-stage data bus: peripheral address map,
// TCON bit positions, bus target select and the 7-segment code table.
package mem_periph_bus_pkg;

  localparam logic [31:0] PERIPH_BASE  = 32'h4000_0000;
  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
  localparam logic [31:0] ADDR_DIGITS  = 32'h4000_0010;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

  localparam int TCON_EN     = 0;
  localparam int TCON_IRQ_EN = 1;
  localparam int TCON_STATUS = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LED,
    SEL_DIGITS,
    SEL_SYSTICK
  } bus_sel_e;

  // Active-low segment pattern {dp,g,f,e,d,c,b,a}, decimal point always off.
  function automatic logic [7:0] seg_code(input logic [3:0] hex);
    logic [7:0] code;
    case (hex)
      4'h0:    code = 8'hC0;
      4'h1:    code = 8'hF9;
      4'h2:    code = 8'hA4;
      4'h3:    code = 8'hB0;
      4'h4:    code = 8'h99;
      4'h5:    code = 8'h92;
      4'h6:    code = 8'h82;
      4'h7:    code = 8'hF8;
      4'h8:    code = 8'h80;
      4'h9:    code = 8'h90;
      4'hA:    code = 8'h88;
      4'hB:    code = 8'h83;
      4'hC:    code = 8'hC6;
      4'hD:    code = 8'hA1;
      4'hE:    code = 8'h86;
      4'hF:    code = 8'h8E;
      default: code = 8'hFF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mem_periph_bus_seg7.sv
// Hex nibble to active-low 7-segment pattern, purely combinational.
module seg7_decoder
  import mem_periph_bus_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [7:0] o_seg
);

  assign o_seg = seg_code(i_hex);

endmodule

// File: rtl/mem_periph_bus.sv
// MEM-stage data bus: data RAM plus memory-mapped reload timer, LEDs,
// multiplexed 4-digit 7-segment display and free-running systick.
module mem_periph_bus
  import mem_periph_bus_pkg::*;
#(
  parameter int RAM_WORDS = 512,
  parameter int SCAN_DIV  = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [7:0]  leds,
  output logic [3:0]  anodes,
  output logic [7:0]  cathodes
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCAN_W = $clog2(SCAN_DIV);

  logic [31:0]       r_ram [RAM_WORDS];
  logic [31:0]       r_th;
  logic [31:0]       r_tl;
  logic [2:0]        r_tcon;
  logic [7:0]        r_led;
  logic [15:0]       r_digits;
  logic [31:0]       r_systick;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [1:0]        r_digit_idx;

  bus_sel_e          w_sel;
  logic [31:0]       w_word_addr;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_wr_en;
  logic [3:0]        w_digit;
  logic              w_unused_byte_lanes;

  assign w_word_addr         = {addr[31:2], 2'b00};
  assign w_ram_idx           = addr[RAM_AW+1:2];
  assign w_wr_en             = mem_write;
  assign w_unused_byte_lanes = ^addr[1:0];

  // Address decode: RAM occupies the bottom of the map, peripherals sit at PERIPH_BASE.
  always_comb begin
    w_sel = SEL_NONE;
    if (addr[31:RAM_AW+2] == '0) begin
      w_sel = SEL_RAM;
    end else begin
      case (w_word_addr)
        ADDR_TH:      w_sel = SEL_TH;
        ADDR_TL:      w_sel = SEL_TL;
        ADDR_TCON:    w_sel = SEL_TCON;
        ADDR_LED:     w_sel = SEL_LED;
        ADDR_DIGITS:  w_sel = SEL_DIGITS;
        ADDR_SYSTICK: w_sel = SEL_SYSTICK;
        default:      w_sel = SEL_NONE;
      endcase
    end
  end

  // Zero-latency read mux; a simultaneous write shows the pre-write value.
  always_comb begin
    rdata = 32'h0000_0000;
    if (mem_read) begin
      case (w_sel)
        SEL_RAM:     rdata = r_ram[w_ram_idx];
        SEL_TH:      rdata = r_th;
        SEL_TL:      rdata = r_tl;
        SEL_TCON:    rdata = {29'd0, r_tcon};
        SEL_LED:     rdata = {24'd0, r_led};
        SEL_DIGITS:  rdata = {16'd0, r_digits};
        SEL_SYSTICK: rdata = r_systick;
        default:     rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  // Data RAM write port; contents intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en && (w_sel == SEL_RAM)) begin
      r_ram[w_ram_idx] <= wdata;
    end
  end

  // Timer, systick and software-visible registers; bus writes are placed last so they win.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th      <= 32'h0000_0000;
      r_tl      <= 32'h0000_0000;
      r_tcon    <= 3'b000;
      r_led     <= 8'h00;
      r_digits  <= 16'h0000;
      r_systick <= 32'h0000_0000;
    end else begin
      r_systick <= r_systick + 32'd1;
      if (r_tcon[TCON_EN]) begin
        if (r_tl == 32'hFFFF_FFFF) begin
          r_tl <= r_th;
          if (r_tcon[TCON_IRQ_EN]) begin
            r_tcon[TCON_STATUS] <= 1'b1;
          end
        end else begin
          r_tl <= r_tl + 32'd1;
        end
      end
      if (w_wr_en) begin
        case (w_sel)
          SEL_TH:     r_th     <= wdata;
          SEL_TL:     r_tl     <= wdata;
          SEL_TCON:   r_tcon   <= wdata[2:0];
          SEL_LED:    r_led    <= wdata[7:0];
          SEL_DIGITS: r_digits <= wdata[15:0];
          default:    r_th     <= r_th;
        endcase
      end
    end
  end

  // Display scan: each digit slot lasts SCAN_DIV cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= 2'd0;
    end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= r_digit_idx + 2'd1;
    end else begin
      r_scan_cnt  <= r_scan_cnt + SCAN_W'(1);
    end
  end

  assign w_digit = r_digits[{r_digit_idx, 2'b00} +: 4];

  seg7_decoder u_seg7 (
    .i_hex (w_digit),
    .o_seg (cathodes)
  );

  assign anodes = ~(4'b0001 << r_digit_idx);
  assign irq    = r_tcon[TCON_IRQ_EN] & r_tcon[TCON_STATUS];
  assign leds   = r_led;

endmodule

// File: tb/tb_mem_periph_bus.sv
// Directed bench for mem_periph_bus: vector table for bus accesses plus
// hand sequences for timer overflow, collisions, display scan and async reset.
module tb_mem_periph_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  leds;
  logic [3:0]  anodes;
  logic [7:0]  cathodes;

  int total = 0;
  int bad   = 0;
  int unsigned n_cyc = 0;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_DIG  = 32'h4000_0010;
  localparam logic [31:0] A_TICK = 32'h4000_0014;

  logic [7:0] seg_exp [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  mem_periph_bus #(.RAM_WORDS(512), .SCAN_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .irq       (irq),
    .leds      (leds),
    .anodes    (anodes),
    .cathodes  (cathodes)
  );

  always #5 clk = ~clk;

  // Reference cycle count since reset release: drives systick and scan expectations.
  always @(posedge clk or posedge reset) begin
    if (reset) n_cyc <= 0;
    else       n_cyc <= n_cyc + 1;
  end

  function automatic vec_t mk(input logic we, input logic re, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] exp, input string name);
    vec_t v;
    v.we = we; v.re = re; v.a = a; v.d = d; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one bus cycle at the falling edge; outputs settle 1 time unit later.
  task automatic bus(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_write = we;
    mem_read  = re;
    addr      = a;
    wdata     = d;
    #1;
  endtask

  initial begin
    logic [1:0]  idx;
    logic [15:0] digs;

    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          "ram_wr_noread"));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF,  "ram_rd"));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0000_0800, 32'h0,         32'h0,          "ram_oob_rd"));
    vecs.push_back(mk(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'hDEAD_BEEF,  "rw_prewrite"));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'h1234_5678,  "rw_after"));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,          "read_disabled"));
    vecs.push_back(mk(1'b1, 1'b0, A_LED,         32'h0000_01A5, 32'h0,          "led_wr"));
    vecs.push_back(mk(1'b0, 1'b1, A_LED,         32'h0,         32'h0000_00A5,  "led_rd"));
    vecs.push_back(mk(1'b1, 1'b0, A_TH,          32'hFFFF_FFFC, 32'h0,          "th_wr"));
    vecs.push_back(mk(1'b0, 1'b1, A_TH,          32'h0,         32'hFFFF_FFFC,  "th_rd"));
    vecs.push_back(mk(1'b1, 1'b0, A_DIG,         32'hABCD_12AF, 32'h0,          "dig_wr"));
    vecs.push_back(mk(1'b0, 1'b1, A_DIG,         32'h0,         32'h0000_12AF,  "dig_rd"));
    vecs.push_back(mk(1'b1, 1'b0, A_TICK,        32'h5,         32'h0,          "tick_wr"));
    vecs.push_back(mk(1'b1, 1'b0, 32'h4000_0020, 32'h5,         32'h0,          "unmap_wr"));
    vecs.push_back(mk(1'b0, 1'b1, 32'h4000_0020, 32'h0,         32'h0,          "unmap_rd"));
    vecs.push_back(mk(1'b0, 1'b1, A_LED,         32'h0,         32'h0000_00A5,  "led_kept"));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_07FC, 32'hCAFE_F00D, 32'h0,          "ram_top_wr"));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0000_07FF, 32'h0,         32'hCAFE_F00D,  "ram_byteoff_rd"));
    vecs.push_back(mk(1'b0, 1'b1, A_TCON,        32'h0,         32'h0,          "tcon_rd"));
    vecs.push_back(mk(1'b0, 1'b1, A_TL,          32'h0,         32'h0,          "tl_rd"));
    vecs.push_back(mk(1'b0, 1'b1, 32'h4000_0018, 32'h0,         32'h0,          "unmap2_rd"));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'h1234_5678,  "ram_kept"));

    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rdata",    rdata,              32'h0);
    check("rst_irq",      {31'd0, irq},       32'h0);
    check("rst_leds",     {24'd0, leds},      32'h0);
    check("rst_anodes",   {28'd0, anodes},    32'hE);
    check("rst_cathodes", {24'd0, cathodes},  32'hC0);
    mem_read = 1'b1; addr = A_TL; #1;
    check("rst_tl",       rdata,              32'h0);
    @(negedge clk);
    reset = 1'b0; mem_read = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus(vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].d);
      check(vecs[i].name, rdata, vecs[i].exp);
    end
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    check("leds_out", {24'd0, leds}, 32'h0000_00A5);

    bus(1'b0, 1'b1, A_TICK, 32'h0);
    check("systick_a", rdata, n_cyc);
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    bus(1'b0, 1'b1, A_TICK, 32'h0);
    check("systick_b", rdata, n_cyc);
    bus(1'b0, 1'b0, 32'h0, 32'h0);

    digs = 16'h12AF;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk); #1;
      idx = 2'((n_cyc / 4) % 4);
      check("scan_anodes",   {28'd0, anodes},   {28'd0, ~(4'b0001 << idx)});
      check("scan_cathodes", {24'd0, cathodes}, {24'd0, seg_exp[(digs >> (4 * idx)) & 16'hF]});
    end

    bus(1'b1, 1'b0, A_TL,   32'hFFFF_FFFC);
    bus(1'b1, 1'b0, A_TCON, 32'h3);
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, 1'b1, A_TL, 32'h0);
      check("tmr_count", rdata, 32'hFFFF_FFFC + i);
    end
    bus(1'b0, 1'b1, A_TL, 32'h0);
    check("tmr_reload", rdata, 32'hFFFF_FFFC);
    check("tmr_irq", {31'd0, irq}, 32'h1);
    bus(1'b0, 1'b1, A_TCON, 32'h0);
    check("tmr_tcon7", rdata, 32'h7);
    check("tmr_irq_held", {31'd0, irq}, 32'h1);
    bus(1'b1, 1'b1, A_TCON, 32'h3);
    check("tmr_clr_pre", rdata, 32'h7);
    bus(1'b0, 1'b1, A_TCON, 32'h0);
    check("tmr_clr_tcon", rdata, 32'h3);
    check("tmr_clr_irq", {31'd0, irq}, 32'h0);

    bus(1'b1, 1'b0, A_TCON, 32'h0);
    bus(1'b1, 1'b0, A_TL,   32'hFFFF_FFFF);
    bus(1'b1, 1'b0, A_TCON, 32'h3);
    bus(1'b1, 1'b0, A_TL,   32'h0000_0010);
    bus(1'b0, 1'b1, A_TL,   32'h0);
    check("col_tl", rdata, 32'h0000_0010);
    check("col_irq", {31'd0, irq}, 32'h1);
    bus(1'b0, 1'b1, A_TCON, 32'h0);
    check("col_tcon", rdata, 32'h7);

    bus(1'b1, 1'b0, A_TCON, 32'h0);
    bus(1'b1, 1'b0, A_TL,   32'hFFFF_FFFF);
    bus(1'b1, 1'b0, A_TCON, 32'h3);
    bus(1'b1, 1'b0, A_TCON, 32'h1);
    bus(1'b0, 1'b1, A_TL,   32'h0);
    check("tconw_tl", rdata, 32'hFFFF_FFFC);
    check("tconw_irq", {31'd0, irq}, 32'h0);
    bus(1'b0, 1'b1, A_TCON, 32'h0);
    check("tconw_tcon", rdata, 32'h1);

    bus(1'b1, 1'b0, A_TH,   32'h0);
    bus(1'b1, 1'b0, A_TL,   32'hFFFF_FFF0);
    bus(1'b1, 1'b0, A_TCON, 32'h3);
    bus(1'b0, 1'b0, 32'h0,  32'h0);
    repeat (50) @(negedge clk);
    #1;
    check("pre_rst_irq", {31'd0, irq}, 32'h1);
    #2;
    reset = 1'b1; mem_read = 1'b1; addr = A_TL; #1;
    check("mid_rst_tl", rdata, 32'h0);
    addr = A_TCON; #1;
    check("mid_rst_tcon",     rdata,             32'h0);
    check("mid_rst_irq",      {31'd0, irq},      32'h0);
    check("mid_rst_leds",     {24'd0, leds},     32'h0);
    check("mid_rst_anodes",   {28'd0, anodes},   32'hE);
    check("mid_rst_cathodes", {24'd0, cathodes}, 32'hC0);
    @(negedge clk);
    reset = 1'b0; mem_read = 1'b0;
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    bus(1'b0, 1'b1, A_TICK, 32'h0);
    check("post_rst_tick", rdata, n_cyc);
    bus(1'b0, 1'b1, A_TL, 32'h0);
    check("post_rst_tl", rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
